bus_src_select_reg: RTL

//  Parametrised, registered bus-source selector for the CPU datapath: selects one of NSRC

---
 rtl/bus_src_select_reg_if.sv | 30 +++
 rtl/bus_src_select_reg.sv | 82 ++++++++
 2 files changed

// File: rtl/bus_src_select_reg_if.sv
// Handshake and bus bundle for the registered bus-source selector.
// slave is the selector's view; master is the driver/consumer side.
interface bus_src_select_reg_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 16,
    parameter int SELW  = 5,
    parameter int ERRW  = 8
);
    logic [NSRC*WIDTH-1:0] src_flat;
    logic [WIDTH-1:0]      ext_data;
    logic [SELW-1:0]       sel;
    logic                  sel_valid;
    logic                  sel_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SELW-1:0]       out_src;
    logic                  err;
    logic [ERRW-1:0]       err_cnt;

    modport slave (
        input  src_flat, ext_data, sel, sel_valid, out_ready,
        output sel_ready, out_data, out_valid, out_src, err, err_cnt
    );

    modport master (
        output src_flat, ext_data, sel, sel_valid, out_ready,
        input  sel_ready, out_data, out_valid, out_src, err, err_cnt
    );
endinterface

// File: rtl/bus_src_select_reg.sv
// Registered bus-source selector with a one-entry output register,
// valid/ready backpressure and illegal-select error counting.
module bus_src_select_reg #(
    parameter int WIDTH     = 16,
    parameter int NSRC      = 16,
    parameter int SELW      = 5,
    parameter bit IDLE_HOLD = 1'b1,
    parameter int ERRW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    bus_src_select_reg_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SELW-1:0] SEL_EXT = SELW'(NSRC + 1);

    state_t          state_q;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  src_q;
    logic             err_q;
    logic [ERRW-1:0]  cnt_q;

    logic             sel_ready;
    logic             accept;
    logic             sel_wait;
    logic             sel_legal;
    logic             sel_illegal;
    logic [WIDTH-1:0] mux_d;

    assign sel_ready   = (state_q == EMPTY) || bus.out_ready;
    assign accept      = bus.sel_valid && sel_ready;
    assign sel_wait    = (bus.sel == '0);
    assign sel_legal   = !sel_wait && (bus.sel <= SEL_EXT);
    assign sel_illegal = !sel_wait && !sel_legal;

    // Compare against each code so no out-of-range index is ever formed
    always_comb begin
        mux_d = bus.ext_data;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.sel == SELW'(i + 1)) begin
                mux_d = bus.src_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (accept && sel_legal) begin
                state_q <= FULL;
                data_q  <= mux_d;
                src_q   <= bus.sel;
            end else if (state_q == FULL && bus.out_ready) begin
                state_q <= EMPTY;
                if (!IDLE_HOLD) data_q <= '0;
            end else if (state_q == EMPTY && !IDLE_HOLD) begin
                data_q <= '0;
            end
            if (accept && sel_illegal) begin
                err_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.sel_ready = sel_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = cnt_q;
endmodule
